// File: rtl/hoaaned_err_corrector_if.sv
// Handshake bus between the HOAANED approximate adder and its error corrector.
// The master side drives operands and the approximate sum; the slave side returns the exact sum.
interface hoaaned_err_corrector_if #(
    parameter int WIDTH = 8,
    parameter int K     = 4,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   approx_sum;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   corr_sum;
    logic             err_flag;
    logic [K-1:0]     err_mag;
    logic             cnt_clr;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, a, b, approx_sum, out_ready, cnt_clr,
        input  in_ready, out_valid, corr_sum, err_flag, err_mag, err_count
    );

    modport slave (
        input  in_valid, a, b, approx_sum, out_ready, cnt_clr,
        output in_ready, out_valid, corr_sum, err_flag, err_mag, err_count
    );
endinterface

// File: rtl/hoaaned_err_corrector.sv
// Corrects the OR-ed low field of a HOAANED approximate sum, rippling the low-field carry
// into the exact upper field one bit per cycle, and counts delivered erroneous results.
module hoaaned_err_corrector #(
    parameter int WIDTH = 8,
    parameter int K     = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hoaaned_err_corrector_if.slave  bus
);
    localparam int IDX_W = $clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0] K_POS    = IDX_W'(K);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - K);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DETECT,
        S_CORRECT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   r_approx;
    logic [WIDTH:0]   r_corr;
    logic             r_err_flag;
    logic [K-1:0]     r_err_mag;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_cnt;

    logic [K:0]       w_lo;
    logic [WIDTH:0]   w_exact;
    logic [IDX_W-1:0] w_pos;
    logic             w_bit;
    logic             w_carry_next;
    logic             w_cnt_inc;

    assign w_lo         = {1'b0, r_a[K-1:0]} + {1'b0, r_b[K-1:0]};
    assign w_exact      = {1'b0, r_a} + {1'b0, r_b};
    assign w_pos        = K_POS + r_idx;
    assign w_bit        = r_corr[w_pos];
    assign w_carry_next = w_bit & r_carry;
    assign w_cnt_inc    = (r_state == S_DONE) && bus.out_ready && r_err_flag && !(&r_cnt);

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.corr_sum  = r_corr;
    assign bus.err_flag  = r_err_flag;
    assign bus.err_mag   = r_err_mag;
    assign bus.err_count = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_approx    <= '0;
            r_corr      <= '0;
            r_err_flag  <= 1'b0;
            r_err_mag   <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            // Clear has priority over a same-cycle increment.
            if (bus.cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_approx   <= bus.approx_sum;
                        r_in_ready <= 1'b0;
                        r_state    <= S_DETECT;
                    end
                end
                S_DETECT: begin
                    r_err_flag <= (r_approx != w_exact);
                    r_err_mag  <= r_a[K-1:0] & r_b[K-1:0];
                    r_corr     <= {r_approx[WIDTH:K], w_lo[K-1:0]};
                    if (w_lo[K]) begin
                        r_idx   <= '0;
                        r_carry <= 1'b1;
                        r_state <= S_CORRECT;
                    end else begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_CORRECT: begin
                    // The upper field never holds all ones, so the ripple always terminates.
                    r_corr[w_pos] <= w_bit ^ r_carry;
                    r_carry       <= w_carry_next;
                    if (!w_carry_next || (r_idx == LAST_IDX)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hoaaned_err_corrector.sv
// Directed and random checks of the error corrector against a scoreboard of exact sums.
// The counter is narrowed to 4 bits so saturation is reachable in a short run.
module tb_hoaaned_err_corrector;
    localparam int WIDTH = 8;
    localparam int K     = 4;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct {
        logic [WIDTH:0] corr;
        logic           flag;
        logic [K-1:0]   mag;
        int             edges;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];
    logic [CNT_W-1:0] expCount;

    hoaaned_err_corrector_if #(.WIDTH(WIDTH), .K(K), .CNT_W(CNT_W)) bus ();

    hoaaned_err_corrector #(.WIDTH(WIDTH), .K(K), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input int holdCycles, input bit clr);
        exp_t           e;
        exp_t           got;
        logic [K:0]     lo;
        logic [WIDTH:0] approx;
        logic [WIDTH:0] held;
        int             ones;
        int             edges;

        lo     = {1'b0, a[K-1:0]} + {1'b0, b[K-1:0]};
        approx = {({1'b0, a[WIDTH-1:K]} + {1'b0, b[WIDTH-1:K]}), (a[K-1:0] | b[K-1:0])};
        e.corr = {1'b0, a} + {1'b0, b};
        e.flag = (approx != e.corr);
        e.mag  = a[K-1:0] & b[K-1:0];
        e.edges = 1;
        if (lo[K]) begin
            ones = 0;
            while (ones < WIDTH - K + 1 && approx[K + ones]) ones++;
            e.edges = 1 + ((ones + 1 > WIDTH - K + 1) ? WIDTH - K + 1 : ones + 1);
        end

        checkOutput("ready_idle", bus.in_ready, 1);
        bus.a          = a;
        bus.b          = b;
        bus.approx_sum = approx;
        bus.in_valid   = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;

        edges = 0;
        while (!bus.out_valid && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput("out_valid", bus.out_valid, 1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            checkOutput("latency", edges, got.edges);
            checkOutput("corr_sum", bus.corr_sum, got.corr);
            checkOutput("err_flag", bus.err_flag, got.flag);
            checkOutput("err_mag", bus.err_mag, got.mag);
        end

        held = bus.corr_sum;
        for (int i = 0; i < holdCycles; i++) begin
            bus.in_valid   = 1'b1;
            bus.a          = ~a;
            bus.b          = b ^ 8'h5A;
            bus.approx_sum = 9'h1AB;
            @(posedge clk); #1;
            checkOutput("hold_valid", bus.out_valid, 1);
            checkOutput("hold_corr", bus.corr_sum, held);
            checkOutput("hold_busy", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;

        bus.out_ready = 1'b1;
        bus.cnt_clr   = clr;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.cnt_clr   = 1'b0;
        if (clr) expCount = '0;
        else if (e.flag && expCount != CNT_MAX) expCount = expCount + 1'b1;
        checkOutput("drop_valid", bus.out_valid, 0);
        checkOutput("back_idle", bus.in_ready, 1);
        checkOutput("corr_kept", bus.corr_sum, held);
        checkOutput("err_count", bus.err_count, expCount);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        expCount = '0;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.approx_sum = '0;
        bus.out_ready  = 1'b0;
        bus.cnt_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", bus.in_ready, 1);
        checkOutput("rst_valid", bus.out_valid, 0);
        checkOutput("rst_corr", bus.corr_sum, 0);
        checkOutput("rst_flag", bus.err_flag, 0);
        checkOutput("rst_mag", bus.err_mag, 0);
        checkOutput("rst_count", bus.err_count, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed transactions");
        applyStimulus(8'h35, 8'h4A, 0, 1'b0);
        applyStimulus(8'h1F, 8'h01, 0, 1'b0);
        applyStimulus(8'h8F, 8'h7F, 0, 1'b0);
        applyStimulus(8'h1F, 8'h01, 10, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 2, 1'b0);
        applyStimulus(8'h00, 8'h00, 0, 1'b0);

        $display("[TB] random transactions");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), i % 3, 1'b0);
        end

        $display("[TB] reset during carry ripple");
        bus.a          = 8'h8F;
        bus.b          = 8'h7F;
        bus.approx_sum = 9'h0FF;
        bus.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        expCount = '0;
        checkOutput("mid_rst_ready", bus.in_ready, 1);
        checkOutput("mid_rst_valid", bus.out_valid, 0);
        checkOutput("mid_rst_count", bus.err_count, 0);
        checkOutput("mid_rst_corr", bus.corr_sum, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checkOutput("no_delivery", bus.out_valid, 0);
        end
        bus.out_ready = 1'b0;

        $display("[TB] counter saturation and clear");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(8'h01, 8'h01, 0, 1'b0);
        end
        checkOutput("saturated", bus.err_count, CNT_MAX);
        applyStimulus(8'h03, 8'h01, 0, 1'b1);
        checkOutput("clr_wins", bus.err_count, 0);
        applyStimulus(8'h02, 8'h02, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
